// File: rtl/color_code_arbiter.sv
// Round-robin arbiter sharing one number-to-colour-pair lookup among N requesters.
// The granted number is looked up and registered, then returned tagged with the requester index.
module color_code_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [6*N-1:0]   req_num,
    output logic [N-1:0]     req_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [IDW-1:0]   resp_id,
    output logic [23:0]      resp_code
);

    // 12-bit RGB colour for one decimal digit.
    function automatic logic [11:0] digit_colour(input logic [3:0] d);
        logic [11:0] c;
        case (d)
            4'd0:    c = 12'h000;
            4'd1:    c = 12'hF00;
            4'd2:    c = 12'hF80;
            4'd3:    c = 12'hFF0;
            4'd4:    c = 12'h0F0;
            4'd5:    c = 12'h0FF;
            4'd6:    c = 12'h08F;
            4'd7:    c = 12'h00F;
            4'd8:    c = 12'hF0F;
            4'd9:    c = 12'hFFF;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    // Binary-to-BCD split followed by the per-digit colour map: {tens, ones}.
    function automatic logic [23:0] color_codes(input logic [5:0] num);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(num / 6'd10);
        ones = 4'(num % 6'd10);
        return {digit_colour(tens), digit_colour(ones)};
    endfunction

    logic             resp_valid_q, resp_valid_d;
    logic [IDW-1:0]   resp_id_q,    resp_id_d;
    logic [23:0]      resp_code_q,  resp_code_d;
    logic [IDW-1:0]   ptr_q,        ptr_d;

    logic             can_accept_s;
    logic             grant_found_s;
    logic             grant_s;
    logic [IDW-1:0]   grant_idx_s;
    logic [5:0]       grant_num_s;

    assign can_accept_s = !rst && (!resp_valid_q || resp_ready);
    assign grant_s      = can_accept_s && grant_found_s;

    // Rotating priority search; scanning the farthest offset first lets the nearest one win.
    always_comb begin
        logic [IDW:0]   sum_v;
        logic [IDW-1:0] cand_v;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        sum_v         = '0;
        cand_v        = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum_v  = {1'b0, ptr_q} + (IDW+1)'(k);
            cand_v = (sum_v >= (IDW+1)'(N)) ? IDW'(sum_v - (IDW+1)'(N)) : sum_v[IDW-1:0];
            if (req_valid[cand_v]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_v;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot ready toward the granted requester.
    always_comb begin
        req_ready = '0;
        if (grant_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Number mux feeding the single shared lookup.
    always_comb begin
        grant_num_s = 6'd0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx_s == IDW'(i)) begin
                grant_num_s = req_num[6*i +: 6];
            end else begin
                grant_num_s = grant_num_s;
            end
        end
    end

    // Next state: load on grant, drop valid when a response leaves with nothing behind it.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_code_d  = resp_code_q;
        ptr_d        = ptr_q;
        if (grant_s) begin
            resp_valid_d = 1'b1;
            resp_id_d    = grant_idx_s;
            resp_code_d  = color_codes(grant_num_s);
            ptr_d        = (grant_idx_s == IDW'(N - 1)) ? '0 : grant_idx_s + IDW'(1);
        end else if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end else begin
            resp_valid_d = resp_valid_q;
        end
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_code_q  <= 24'h000000;
            ptr_q        <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_code_q  <= resp_code_d;
            ptr_q        <= ptr_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_code  = resp_code_q;

endmodule

// File: tb/tb_color_code_arbiter.sv
// Self-checking bench for color_code_arbiter: directed scenarios plus randomized traffic
// compared against a queue-free arithmetic reference of the arbitration rules.
module tb_color_code_arbiter;

    localparam int N = 4;
    localparam logic [11:0] PAL [10] = '{12'h000, 12'hF00, 12'hF80, 12'hFF0, 12'h0F0,
                                         12'h0FF, 12'h08F, 12'h00F, 12'hF0F, 12'hFFF};

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [23:0] req_num;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [23:0] resp_code;

    logic [2:0]  req_valid3;
    logic [17:0] req_num3;
    logic [2:0]  req_ready3;
    logic        resp_valid3;
    logic        resp_ready3;
    logic [1:0]  resp_id3;
    logic [23:0] resp_code3;

    int checks   = 0;
    int failures = 0;

    int          m_ptr  = 0;
    bit          m_rv   = 1'b0;
    int          m_id   = 0;
    logic [23:0] m_code = 24'h0;
    logic [3:0]  exp_ready;

    always #5 clk = ~clk;

    color_code_arbiter #(.N(4)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_num(req_num),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_code(resp_code)
    );

    color_code_arbiter #(.N(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_num(req_num3),
        .req_ready(req_ready3), .resp_valid(resp_valid3), .resp_ready(resp_ready3),
        .resp_id(resp_id3), .resp_code(resp_code3)
    );

    function automatic logic [23:0] ref_code(input int n);
        return {PAL[n / 10], PAL[n % 10]};
    endfunction

    function automatic int ref_grant(input logic [3:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function void calc_exp();
        int g;
        exp_ready = 4'b0000;
        if (!rst && (!m_rv || resp_ready)) begin
            g = ref_grant(req_valid, m_ptr);
            if (g >= 0) exp_ready[g] = 1'b1;
        end
    endfunction

    function void model_edge();
        int g;
        if (rst) begin
            m_ptr = 0; m_rv = 1'b0; m_id = 0; m_code = 24'h0;
        end else begin
            g = (!m_rv || resp_ready) ? ref_grant(req_valid, m_ptr) : -1;
            if (g >= 0) begin
                m_rv   = 1'b1;
                m_id   = g;
                m_code = ref_code(int'(req_num[6*g +: 6]));
                m_ptr  = (g + 1) % N;
            end else if (m_rv && resp_ready) begin
                m_rv = 1'b0;
            end
        end
    endfunction

    task automatic to_sample();
        @(negedge clk);
        calc_exp();
    endtask

    task automatic to_next();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 4'b0; req_valid3 = 3'b0; resp_ready = 1'b0; resp_ready3 = 1'b0;
        to_next();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; req_num = 24'($urandom); resp_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            to_sample();
            checks++;
            if (req_ready !== 4'b0000) begin
                failures++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
            end
            to_next();
        end
        rst = 1'b0; req_valid = 4'b0;
        to_sample();
        checks++;
        if (resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_code !== 24'h000000) begin
            failures++;
            $display("FAIL reset_values: got v=%b id=%0d code=%h expected v=0 id=0 code=000000",
                     resp_valid, resp_id, resp_code);
        end
        to_next();
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0100; req_num = 24'd0; req_num[17:12] = 6'd42; resp_ready = 1'b1;
        to_sample();
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++; $display("FAIL single_grant: got %b expected 0100", req_ready);
        end
        to_next();
        req_valid = 4'b0000;
        to_sample();
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_code !== 24'h0F0F80 || req_ready !== 4'b0) begin
            failures++;
            $display("FAIL single_resp: got v=%b id=%0d code=%h rdy=%b expected v=1 id=2 code=0F0F80 rdy=0000",
                     resp_valid, resp_id, resp_code, req_ready);
        end
        to_next();
        req_valid = 4'b1111;
        to_sample();
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++; $display("FAIL single_ptr3: got %b expected 1000", req_ready);
        end
        to_next();
    endtask

    task automatic test_round_robin();
        logic [23:0] codes [4];
        logic [3:0]  expv;
        codes = '{24'h000000, 24'h000FFF, 24'hF0000F, 24'h08FFF0};
        do_reset();
        req_valid = 4'b1111; req_num = {6'd63, 6'd17, 6'd9, 6'd0}; resp_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            to_sample();
            expv = 4'b0001 << (c % 4);
            checks++;
            if (req_ready !== expv) begin
                failures++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, req_ready, expv);
            end
            if (c > 0) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== 2'((c - 1) % 4) || resp_code !== codes[(c - 1) % 4]) begin
                    failures++;
                    $display("FAIL rr_resp c=%0d: got v=%b id=%0d code=%h expected v=1 id=%0d code=%h",
                             c, resp_valid, resp_id, resp_code, (c - 1) % 4, codes[(c - 1) % 4]);
                end
            end
            to_next();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b1010; req_num = 24'd0; req_num[11:6] = 6'd5; req_num[23:18] = 6'd33;
        resp_ready = 1'b1;
        to_sample();
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++; $display("FAIL bp_first: got %b expected 0010", req_ready);
        end
        to_next();
        resp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            to_sample();
            checks++;
            if (req_ready !== 4'b0 || resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_code !== 24'h0000FF) begin
                failures++;
                $display("FAIL bp_hold c=%0d: got rdy=%b v=%b id=%0d code=%h expected rdy=0000 v=1 id=1 code=0000FF",
                         c, req_ready, resp_valid, resp_id, resp_code);
            end
            to_next();
        end
        resp_ready = 1'b1;
        to_sample();
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++; $display("FAIL bp_release: got %b expected 1000", req_ready);
        end
        to_next();
        to_sample();
        checks++;
        if (resp_id !== 2'd3 || resp_code !== 24'hFF0FF0 || req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_after: got id=%0d code=%h rdy=%b expected id=3 code=FF0FF0 rdy=0010",
                     resp_id, resp_code, req_ready);
        end
        to_next();
    endtask

    task automatic test_wrap_skip();
        logic [3:0] expv;
        do_reset();
        req_valid = 4'b0100; req_num = 24'd0; resp_ready = 1'b1;
        to_next();
        req_valid = 4'b0011; req_num = 24'd0; req_num[5:0] = 6'd11; req_num[11:6] = 6'd22;
        for (int c = 0; c < 6; c++) begin
            to_sample();
            expv = (c % 2 == 0) ? 4'b0001 : 4'b0010;
            checks++;
            if (req_ready !== expv) begin
                failures++; $display("FAIL wrap_skip c=%0d: got %b expected %b", c, req_ready, expv);
            end
            to_next();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b0100; req_num = 24'd0; req_num[17:12] = 6'd50; resp_ready = 1'b1;
        to_next();
        req_valid = 4'b1011; resp_ready = 1'b0;
        to_sample();
        checks++;
        if (resp_valid !== 1'b1 || req_ready !== 4'b0) begin
            failures++; $display("FAIL rmid_pending: got v=%b rdy=%b expected v=1 rdy=0000", resp_valid, req_ready);
        end
        to_next();
        rst = 1'b1; resp_ready = 1'b1;
        to_sample();
        checks++;
        if (req_ready !== 4'b0) begin
            failures++; $display("FAIL rmid_rst_ready: got %b expected 0000", req_ready);
        end
        to_next();
        rst = 1'b0; resp_ready = 1'b0;
        to_sample();
        checks++;
        if (resp_valid !== 1'b0 || resp_code !== 24'h0 || resp_id !== 2'd0 || req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rmid_after: got v=%b id=%0d code=%h rdy=%b expected v=0 id=0 code=000000 rdy=0001",
                     resp_valid, resp_id, resp_code, req_ready);
        end
        to_next();
    endtask

    task automatic test_lookup();
        do_reset();
        req_valid = 4'b0001; resp_ready = 1'b1;
        for (int n = 0; n <= 64; n++) begin
            req_num = 24'd0;
            req_num[5:0] = 6'(n);
            req_valid = (n < 64) ? 4'b0001 : 4'b0000;
            to_sample();
            if (n > 0) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_code !== ref_code(n - 1)) begin
                    failures++;
                    $display("FAIL lookup num=%0d: got v=%b id=%0d code=%h expected v=1 id=0 code=%h",
                             n - 1, resp_valid, resp_id, resp_code, ref_code(n - 1));
                end
                if (n - 1 == 59 || n - 1 == 60) begin
                    checks++;
                    if (resp_code !== ((n - 1 == 59) ? 24'h0FFFFF : 24'h08F000)) begin
                        failures++; $display("FAIL lookup_fixed num=%0d: got %h", n - 1, resp_code);
                    end
                end
            end
            to_next();
        end
    endtask

    task automatic test_random();
        bit         pending [4];
        logic [5:0] pnum [4];
        int         waits [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pending[i] = 1'b0; pnum[i] = 6'd0; waits[i] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pending[i] && $urandom_range(0, 2) == 0) begin
                    pending[i] = 1'b1; pnum[i] = 6'($urandom_range(0, 63));
                end
                req_valid[i] = pending[i];
                req_num[6*i +: 6] = pnum[i];
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 39) == 0);
            to_sample();
            checks++;
            if (req_ready !== exp_ready || resp_valid !== m_rv || resp_id !== 2'(m_id) || resp_code !== m_code) begin
                failures++;
                $display("FAIL random c=%0d: got rdy=%b v=%b id=%0d code=%h expected rdy=%b v=%b id=%0d code=%h",
                         c, req_ready, resp_valid, resp_id, resp_code, exp_ready, m_rv, m_id, m_code);
            end
            for (int i = 0; i < 4; i++) begin
                if (rst) begin
                    waits[i] = 0;
                end else if (exp_ready[i]) begin
                    checks++;
                    if (waits[i] > N - 1) begin
                        failures++; $display("FAIL starvation req=%0d: waited %0d grants, bound %0d", i, waits[i], N - 1);
                    end
                    pending[i] = 1'b0; waits[i] = 0;
                end else if (pending[i] && exp_ready != 4'b0) begin
                    waits[i]++;
                end
            end
            to_next();
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap_n3();
        int         nums [3];
        logic [2:0] expv;
        nums = '{7, 10, 20};
        do_reset();
        req_valid3 = 3'b111; req_num3 = {6'd20, 6'd10, 6'd7}; resp_ready3 = 1'b1;
        for (int c = 0; c < 7; c++) begin
            to_sample();
            expv = 3'(1 << (c % 3));
            checks++;
            if (req_ready3 !== expv) begin
                failures++; $display("FAIL n3_grant c=%0d: got %b expected %b", c, req_ready3, expv);
            end
            if (c > 0) begin
                checks++;
                if (resp_valid3 !== 1'b1 || resp_id3 !== 2'((c - 1) % 3) || resp_code3 !== ref_code(nums[(c - 1) % 3])) begin
                    failures++;
                    $display("FAIL n3_resp c=%0d: got v=%b id=%0d code=%h expected v=1 id=%0d code=%h",
                             c, resp_valid3, resp_id3, resp_code3, (c - 1) % 3, ref_code(nums[(c - 1) % 3]));
                end
            end
            to_next();
        end
        req_valid3 = 3'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 4'b0; req_num = 24'd0; resp_ready = 1'b0;
        req_valid3 = 3'b0; req_num3 = 18'd0; resp_ready3 = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
        test_reset_mid();
        test_lookup();
        test_wrap_n3();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/color_code_arbiter.md
# color_code_arbiter

Round-robin arbiter that shares one `color_codes` lookup (6-bit number to 24-bit tens/ones colour pair) among N independent requesters. Each requester presents a number under a valid/ready handshake. The arbiter grants one requester per cycle, registers the looked-up colour pair, and returns it tagged with the requester index on a single valid/ready response channel. It sits between the display/LED client blocks and the single `color_codes` instance.

## Interface
- `N`, default 4: number of requesters; legal range 2..8.
- `IDW`, default `$clog2(N)`: width of the requester index.

- `clk` in, 1: system clock; all state updates on the rising edge.
- `rst` in, 1: reset, synchronous and active-high. One clock; reset is synchronous and active-high.
- `req_valid` in, N: bit i means requester i presents a number.
- `req_num` in, 6*N: requester i number in bits [6i+5:6i]; range 0..63.
- `req_ready` out, N: one-hot or zero; bit i high means requester i's number is taken this cycle.
- `resp_valid` out, 1: the response registers hold a result.
- `resp_ready` in, 1: the consumer accepts the response this cycle.
- `resp_id` out, IDW: index of the requester that produced the response.
- `resp_code` out, 24: `color_codes` output for the granted number, {tens colour, ones colour}.

## Operation
- Internal state consists of:
  - `resp_valid`, `resp_id` and `resp_code` registers.
  - A round-robin pointer `ptr` (IDW bits).
- **Accept condition:** `can_accept = !rst && (!resp_valid || resp_ready)`.
- **Grant:** when `can_accept` and `req_valid != 0`, grant index g is the first i with `req_valid[i]=1`, searching ptr, ptr+1, ... wrapping modulo N.
  - `req_ready[g]=1`; all other bits are 0.
  - Otherwise `req_ready=0`.
  - `req_ready` is combinational from `req_valid`, `ptr`, `resp_valid`, `resp_ready` and `rst`.
- **On a grant edge:**
  - `resp_code <= color_codes(req_num[g])`, driven through one `color_codes` instance fed by a mux on g.
  - `resp_id <= g`.
  - `resp_valid <= 1`.
  - `ptr <= (g+1) mod N`, with the wrap for non-power-of-2 N computed explicitly.
- **Response completes with no new grant** (`resp_valid && resp_ready`, nothing granted): `resp_valid <= 0`. `resp_id` and `resp_code` hold their values.
- **Response completes and a grant occurs in the same cycle:** the registers load the new grant and `resp_valid` stays 1. This gives back-to-back throughput of one result per cycle.
- **Backpressure** (`resp_valid && !resp_ready`): `req_ready=0`; all registers and `ptr` hold.
- **`ptr` only moves on a grant.** An idle cycle never moves it.
- **Starvation bound:** a continuously requesting requester is granted within N grants.
- **Contents of `resp_code`:**
  - Colour map, 12-bit RGB per digit: 0=000, 1=F00, 2=F80, 3=FF0, 4=0F0, 5=0FF, 6=08F, 7=00F, 8=F0F, 9=FFF.
  - tens = num/10 and ones = num%10, taken from the existing `bcd` block.
- **Requester obligation:** a requester holds `req_num` stable while `req_valid=1` and it has not been granted. The arbiter does not check this.

## Timing
- **Reset values** (the edge with `rst=1` sets them; this has priority over every other update, including a pending response):
  - `resp_valid=0`, `resp_id=0`, `resp_code=24'h000000`, `ptr=0`.
  - `req_ready=0` for the whole cycle in which `rst=1`.
- **Latency:** grant in cycle T gives `resp_valid=1` with data in cycle T+1.
- **Reset mid-operation:** a pending unaccepted response is discarded. Requesters re-arbitrate starting from index 0.
- **No combinational path** from `req_valid` or `req_num` to any `resp_*` output.
- `resp_ready` is combinational into `req_ready` only. No loop exists, because `resp_valid` is registered.
- **Timing constraint:** the worst-case path is the grant mux into `bcd` and `color_codes` into `resp_code`. It must close at the system clock.

## Test plan
- **Single request:** reset, then `req_valid=4'b0100` with num2=42.
  - `req_ready=4'b0100` for one cycle.
  - Next cycle: `resp_valid=1`, `resp_id=2`, `resp_code=24'h0F0F80`.
  - `ptr` becomes 3.
- **Round-robin under full load:** all four valid, nums 0, 9, 17, 63; `resp_ready=1` constantly.
  - Grants come in the order 0, 1, 2, 3, 0, ... with one grant per cycle.
  - Codes: 24'h000000, 24'h000FFF, 24'hF0000F, 24'h08FFF0.
- **Backpressure:** `resp_ready=0` for 3 cycles while requests 1 and 3 are pending.
  - `resp_*` and `ptr` stay stable and `req_ready=0`.
  - When `resp_ready` returns to 1, the same cycle grants the next index after the served one.
- **Wrap and skip:** `ptr=3`, `req_valid=4'b0011`.
  - Grant goes to 0, then 1; requester 2 is never granted.
  - With N=3 (params), the pointer wraps 2 to 0.
- **Reset mid-operation:** assert `rst` while `resp_valid=1` and `resp_ready=0`.
  - The next cycle shows `resp_valid=0`, `resp_code=0`, `ptr=0`.
  - `req_ready=0` during reset, and the first grant after reset goes to the lowest valid index.
- **Exhaustive lookup:** sweep num 0..63 through requester 0.
  - Each `resp_code` matches the colour map, e.g. 59 gives 24'h0FFFFF and 60 gives 24'h08F000.
